// File: rtl/branch_seq.sv
// Branch sequencer for the 8085-style core: decodes JMP/CALL/RET from the fetched byte stream
// and drives the PC load interface. Define BRANCH_SEQ_COND_EN to decode JNZ/JZ/JNC/JC.
module branch_seq #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned SP_W  = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [15:0]     i_pc,
   input  logic [7:0]      i_instr_byte,
   input  logic            i_flag_z,
   input  logic            i_flag_cy,
   output logic            o_control,
   output logic [15:0]     o_branch_addr,
   output logic [SP_W:0]   o_stk_depth,
   output logic            o_stk_underflow
);

   localparam int unsigned AW = 16;
   localparam int unsigned DW = SP_W + 1;

   localparam logic [7:0] OP_JMP  = 8'hC3;
   localparam logic [7:0] OP_CALL = 8'hCD;
   localparam logic [7:0] OP_RET  = 8'hC9;
`ifdef BRANCH_SEQ_COND_EN
   localparam logic [7:0] OP_JNZ  = 8'hC2;
   localparam logic [7:0] OP_JZ   = 8'hCA;
   localparam logic [7:0] OP_JNC  = 8'hD2;
   localparam logic [7:0] OP_JC   = 8'hDA;
`endif

   typedef enum logic [2:0] {
      S_OP    = 3'd0,
      S_LO    = 3'd1,
      S_HI    = 3'd2,
      S_BR    = 3'd3,
      S_RET   = 3'd4,
      S_SKIP2 = 3'd5,
      S_SKIP1 = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      K_JMP  = 3'd0,
      K_CALL = 3'd1,
      K_JNZ  = 3'd2,
      K_JZ   = 3'd3,
      K_JNC  = 3'd4,
      K_JC   = 3'd5
   } kind_t;

   // Instruction length in bytes; branch opcodes are intercepted before this is consulted.
   function automatic logic [1:0] op_len(input logic [7:0] op);
      case (op)
         8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
         8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
         8'hD3, 8'hDB:
            op_len = 2'd2;
         8'h01, 8'h11, 8'h21, 8'h31, 8'h22, 8'h2A, 8'h32, 8'h3A,
         8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hE2, 8'hEA, 8'hF2, 8'hFA,
         8'hC4, 8'hCC, 8'hD4, 8'hDC, 8'hE4, 8'hEC, 8'hF4, 8'hFC,
         8'hC3, 8'hCD:
            op_len = 2'd3;
         default:
            op_len = 2'd1;
      endcase
   endfunction

   state_t             r_state;
   state_t             w_state_nx;
   kind_t              r_kind;
   kind_t              w_kind_nx;
   logic [7:0]         r_lo;
   logic [7:0]         w_lo_nx;
   logic               r_control;
   logic               w_control_nx;
   logic [AW-1:0]      r_branch_addr;
   logic [AW-1:0]      w_addr_nx;
   logic               r_underflow;
   logic               w_uf_set;
   logic               w_push;
   logic               w_pop;
   logic               w_take;

   logic [AW-1:0]      r_stack [DEPTH];
   logic [SP_W-1:0]    r_ptr;
   logic [DW-1:0]      r_depth;
   logic [SP_W-1:0]    w_ptr_inc;
   logic [SP_W-1:0]    w_top;
   logic               w_stk_nonempty;

`ifndef BRANCH_SEQ_COND_EN
   logic w_unused_flags;
   assign w_unused_flags = i_flag_z ^ i_flag_cy;
`endif

   // r_ptr is the next free slot; the top entry sits one below it (circularly).
   assign w_ptr_inc      = (r_ptr == SP_W'(DEPTH - 1)) ? '0 : r_ptr + SP_W'(1);
   assign w_top          = (r_ptr == '0) ? SP_W'(DEPTH - 1) : r_ptr - SP_W'(1);
   assign w_stk_nonempty = (r_depth != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_OP;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_kind_nx    = r_kind;
      w_lo_nx      = r_lo;
      w_control_nx = 1'b0;
      w_addr_nx    = r_branch_addr;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_uf_set     = 1'b0;
      w_take       = 1'b0;

      case (r_state)
         S_OP: begin
            if (i_instr_byte == OP_JMP) begin
               w_kind_nx  = K_JMP;
               w_state_nx = S_LO;
            end else if (i_instr_byte == OP_CALL) begin
               w_kind_nx  = K_CALL;
               w_state_nx = S_LO;
`ifdef BRANCH_SEQ_COND_EN
            end else if (i_instr_byte == OP_JNZ) begin
               w_kind_nx  = K_JNZ;
               w_state_nx = S_LO;
            end else if (i_instr_byte == OP_JZ) begin
               w_kind_nx  = K_JZ;
               w_state_nx = S_LO;
            end else if (i_instr_byte == OP_JNC) begin
               w_kind_nx  = K_JNC;
               w_state_nx = S_LO;
            end else if (i_instr_byte == OP_JC) begin
               w_kind_nx  = K_JC;
               w_state_nx = S_LO;
`endif
            end else if (i_instr_byte == OP_RET) begin
               // Return target is launched from here so control lines up with S_RET.
               if (w_stk_nonempty) begin
                  w_control_nx = 1'b1;
                  w_addr_nx    = r_stack[w_top];
               end
               w_state_nx = S_RET;
            end else begin
               case (op_len(i_instr_byte))
                  2'd3:    w_state_nx = S_SKIP2;
                  2'd2:    w_state_nx = S_SKIP1;
                  default: w_state_nx = S_OP;
               endcase
            end
         end

         S_LO: begin
            w_lo_nx    = i_instr_byte;
            w_state_nx = S_HI;
         end

         S_HI: begin
            case (r_kind)
               K_JMP, K_CALL: w_take = 1'b1;
`ifdef BRANCH_SEQ_COND_EN
               K_JNZ:         w_take = ~i_flag_z;
               K_JZ:          w_take = i_flag_z;
               K_JNC:         w_take = ~i_flag_cy;
               K_JC:          w_take = i_flag_cy;
`endif
               default:       w_take = 1'b0;
            endcase
            if (w_take) begin
               w_control_nx = 1'b1;
               w_addr_nx    = {i_instr_byte, r_lo};
               w_state_nx   = S_BR;
            end else begin
               w_state_nx   = S_OP;
            end
         end

         S_BR: begin
            // The PC already points past the operands here: that is the return address.
            w_push     = (r_kind == K_CALL);
            w_state_nx = S_OP;
         end

         S_RET: begin
            w_pop      = w_stk_nonempty;
            w_uf_set   = ~w_stk_nonempty;
            w_state_nx = S_OP;
         end

         S_SKIP2: w_state_nx = S_SKIP1;
         S_SKIP1: w_state_nx = S_OP;
         default: w_state_nx = S_OP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_kind        <= K_JMP;
         r_lo          <= 8'h00;
         r_control     <= 1'b0;
         r_branch_addr <= 16'h0000;
         r_underflow   <= 1'b0;
      end else begin
         r_kind        <= w_kind_nx;
         r_lo          <= w_lo_nx;
         r_control     <= w_control_nx;
         r_branch_addr <= w_addr_nx;
         if (w_uf_set) begin
            r_underflow <= 1'b1;
         end
      end
   end

   // Push on a full stack overwrites the oldest slot, so depth saturates at DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr   <= '0;
         r_depth <= '0;
      end else if (w_push) begin
         r_ptr <= w_ptr_inc;
         if (r_depth != DW'(DEPTH)) begin
            r_depth <= r_depth + DW'(1);
         end
      end else if (w_pop) begin
         r_ptr   <= w_top;
         r_depth <= r_depth - DW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_stack[r_ptr] <= i_pc;
      end
   end

   assign o_control       = r_control;
   assign o_branch_addr   = r_branch_addr;
   assign o_stk_depth     = r_depth;
   assign o_stk_underflow = r_underflow;

endmodule

// File: doc/branch_seq.md
Name: branch_seq

Overview:
- Instruction-stream branch sequencer for the 8085-style core.
- Watches the byte fetched at the current program-counter address, tracks opcode and operand boundaries, and decides JMP/CALL/RET.
- Drives the program counter's `control` and `branch_addr` inputs, so it is the producing side of that interface.
- Holds a small return-address stack for CALL/RET.

Parameters:
- DEPTH, 8, return-stack entries (2..16).
- SP_W, 3, stack-pointer width; must satisfy 2^SP_W >= DEPTH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- pc  in  16  current program counter value.
- instr_byte  in  8  memory byte at address pc, valid in the same cycle.
- flag_z  in  1  CPU zero flag.
- flag_cy  in  1  CPU carry flag.
- control  out  1  registered; 1 = load branch_addr into PC at next edge.
- branch_addr  out  16  registered branch target.
- stk_depth  out  SP_W+1  current number of valid stack entries.
- stk_underflow  out  1  sticky; set when RET is executed on an empty stack.

Behaviour:
- Reset values: control=0, branch_addr=16'h0000, stk_depth=0, stk_underflow=0, state=S_OP, stack contents don't-care. Reset mid-instruction abandons it; the next cycle is treated as an opcode.
- States:
  - S_OP: classify instr_byte.
  - S_LO: latch low target byte.
  - S_HI: latch high target byte, evaluate the branch condition.
  - S_BR: control=1, the PC loads the target.
  - S_RET: control=1 with the popped address.
  - S_SKIP2, S_SKIP1: discard operand bytes.
- Byte-length table:
  - 2-byte opcodes: 06,0E,16,1E,26,2E,36,3E,C6,CE,D6,DE,E6,EE,F6,FE,D3,DB.
  - 3-byte opcodes: 01,11,21,31,22,2A,32,3A, all Jcc/Ccc.
  - Everything else is 1-byte.
- S_OP transitions:
  - C3 (JMP), CD (CALL), decoded Jcc -> S_LO.
  - C9 (RET) -> S_RET.
  - Other 3-byte opcodes -> S_SKIP2.
  - 2-byte opcodes -> S_SKIP1.
  - 1-byte opcodes -> S_OP.
- Skip states: S_SKIP2 -> S_SKIP1 -> S_OP; the bytes are ignored.
- S_LO: lo <= instr_byte -> S_HI.
- S_HI: hi <= instr_byte; take = 1 for JMP/CALL, or the condition result for Jcc.
  - If take: register control=1 and branch_addr={instr_byte,lo}, then -> S_BR.
  - If not taken: -> S_OP.
- S_BR (control high this cycle):
  - pc equals the instruction address+3; instr_byte is ignored.
  - For CALL, push pc (the return address).
  - Clear control at the edge, then -> S_OP.
  - The next cycle sees pc = target.
- Branch latency: 4 cycles from opcode to target on the PC (opcode, lo, hi, S_BR).
- S_RET:
  - If stk_depth > 0: control=1 and branch_addr = top entry are registered on the S_OP edge; the entry is popped in S_RET; then -> S_OP.
  - If stk_depth = 0: set stk_underflow, no branch, -> S_OP. The PC simply continues.
- Stack push when full (stk_depth = DEPTH):
  - Circular overwrite of the oldest entry.
  - stk_depth stays DEPTH.
  - The DEPTH most recent return addresses remain retrievable.
- control is asserted for exactly one cycle per taken branch and is never asserted in back-to-back cycles.
- branch_addr holds its last value when control=0.
- No simultaneous push/pop is possible: CALL and RET are serialized by the FSM.
- pc wrap (FFFF->0000) needs no special handling; the return address is taken verbatim from the pc port.

Optional Feature:
- Macro: BRANCH_SEQ_COND_EN.
- Defined: conditional jumps are decoded in S_HI.
  - C2 JNZ: take = !flag_z.
  - CA JZ: take = flag_z.
  - D2 JNC: take = !flag_cy.
  - DA JC: take = flag_cy.
  - Flags are sampled in the S_HI cycle.
- Undefined: these four opcodes follow the S_SKIP2 path, are never taken, and flag_z/flag_cy are unused.
- Other Jcc and all Ccc opcodes use the skip path in both builds.

Test Plan:
- Reset held 2 cycles mid-S_LO, then byte 3E -> control=0, branch_addr=0000, stk_depth=0; 3E is handled as an opcode and enters S_SKIP1.
- Stream at 0010: C3 34 12 -> control=1 for exactly one cycle, when pc=0013, with branch_addr=1234; the next cycle has pc=1234 and state S_OP.
- CALL at 0100: CD 00 20, then RET at 2000 -> push 0103 (stk_depth=1); control with branch_addr=0103 when pc=2001; stk_depth returns to 0.
- DEPTH=8, nine nested CALLs (return addrs A1..A9), then nine RETs -> stk_depth saturates at 8; RETs return A9..A2; the 9th RET sets stk_underflow with no control pulse.
- BRANCH_SEQ_COND_EN defined, CA 00 30 with flag_z=1 -> branch to 3000; same with flag_z=0 -> no control, PC continues at addr+3. Macro undefined -> never taken.
- Skip check: 3A 00 C3 00 followed by C9 on an empty stack -> the C3 operand byte is not decoded as JMP; the RET sets stk_underflow only.
